alu_req_scheduler: RTL and testbench

- Shares one multi-cycle 3-bit ALU engine between NUM_REQ requesters. Each requester presents opcode plus two 3-bit operands using a valid/ready handshake.
- The scheduler arbitrates among requesters, sequences the engine (single-cycle add/sub, 3-cycle shift-add multiply and restoring divide), and returns a tagged 6-bit result over a response handshake.
- Sits between the input-decode logic and the output pins.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_seq_core.sv | 83 ++++++++
 rtl/alu_req_scheduler.sv | 139 +++++++++++++
 tb/tb_alu_req_scheduler.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, widths and scheduler state encoding for the ALU request scheduler
package alu_pkg;

    localparam int OPND_W = 3;
    localparam int RES_W  = 6;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam logic [RES_W-1:0] DZ_RESULT = 6'h3F;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_seq_core.sv
// rtl/alu_seq_core.sv - 3-bit ALU engine: 1-cycle add/sub, 3-step shift-add multiply and restoring divide
module alu_seq_core
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [OPND_W-1:0] a,
    input  logic [OPND_W-1:0] b,
    output logic              done,
    output logic [RES_W-1:0]  result,
    output logic              dz
);

    logic [1:0]        cnt;
    logic [1:0]        step;
    logic [RES_W-1:0]  acc;
    logic [RES_W-1:0]  acc_in;
    logic [RES_W-1:0]  acc_nx;
    logic [OPND_W-1:0] rem;
    logic [OPND_W-1:0] rem_in;
    logic [OPND_W-1:0] rem_nx;
    logic [OPND_W-1:0] quo;
    logic [OPND_W-1:0] quo_in;
    logic [OPND_W-1:0] quo_nx;
    logic [OPND_W:0]   trial;
    logic              a_bit;
    logic              b_bit;
    logic              q_bit;

    // start restarts the accumulators so operands only need to hold during EXEC
    always_comb begin
        step   = start ? 2'd0 : cnt;
        acc_in = start ? '0 : acc;
        rem_in = start ? '0 : rem;
        quo_in = start ? '0 : quo;

        case (step)
            2'd0:    begin b_bit = b[0]; a_bit = a[2]; end
            2'd1:    begin b_bit = b[1]; a_bit = a[1]; end
            default: begin b_bit = b[2]; a_bit = a[0]; end
        endcase

        acc_nx = acc_in + (b_bit ? (RES_W'(a) << step) : '0);

        // partial remainder never exceeds b, so the difference fits in OPND_W bits
        trial = {rem_in, a_bit};
        if (trial >= {1'b0, b}) begin
            rem_nx = OPND_W'(trial - {1'b0, b});
            q_bit  = 1'b1;
        end else begin
            rem_nx = trial[OPND_W-1:0];
            q_bit  = 1'b0;
        end
        quo_nx = {quo_in[OPND_W-2:0], q_bit};

        dz   = (op == OP_DIV) && (b == '0);
        done = op[1] ? (step == 2'd2) : start;

        case (op)
            OP_ADD:  result = RES_W'(a) + RES_W'(b);
            OP_SUB:  result = RES_W'(a) - RES_W'(b);
            OP_MUL:  result = acc_nx;
            default: result = dz ? DZ_RESULT : RES_W'(quo_nx);
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            acc <= '0;
            rem <= '0;
            quo <= '0;
        end else begin
            cnt <= step + 2'd1;
            acc <= acc_nx;
            rem <= rem_nx;
            quo <= quo_nx;
        end
    end

endmodule

// File: rtl/alu_req_scheduler.sv
// rtl/alu_req_scheduler.sv - arbitrates NUM_REQ requesters onto one ALU engine; ALU_FIXED_PRIO_EN selects fixed priority
module alu_req_scheduler
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                  CLK,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [2*NUM_REQ-1:0]  req_op,
    input  logic [3*NUM_REQ-1:0]  req_a,
    input  logic [3*NUM_REQ-1:0]  req_b,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [ID_W-1:0]       resp_id,
    output logic [RES_W-1:0]      resp_result,
    output logic                  resp_dz,
    output logic                  busy
);

    state_t            state;
    state_t            state_nx;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   win;
    logic              found;
    int                idx_c;
    logic              accept;
    logic              start_r;
    logic [1:0]        op_r;
    logic [OPND_W-1:0] a_r;
    logic [OPND_W-1:0] b_r;
    logic [ID_W-1:0]   id_r;
    logic [RES_W-1:0]  res_r;
    logic              dz_r;
    logic              core_done;
    logic [RES_W-1:0]  core_result;
    logic              core_dz;

`ifdef ALU_FIXED_PRIO_EN
    assign ptr = '0;
`else
    logic [ID_W-1:0] rr_ptr;

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            rr_ptr <= '0;
        end else if (state == RESP && resp_ready) begin
            rr_ptr <= (id_r == ID_W'(NUM_REQ - 1)) ? '0 : id_r + ID_W'(1);
        end
    end

    assign ptr = rr_ptr;
`endif

    // first set request at or after ptr, wrapping modulo NUM_REQ
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx_c = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_c = (int'(ptr) + k) % NUM_REQ;
            if (!found && req_valid[idx_c]) begin
                found = 1'b1;
                win   = ID_W'(idx_c);
            end
        end
    end

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (found)      state_nx = EXEC;
            EXEC:    if (core_done)  state_nx = RESP;
            RESP:    if (resp_ready) state_nx = IDLE;
            default:                 state_nx = IDLE;
        endcase
    end

    // req_ready is gated by rst so the grant strobe stays low while reset is held
    always_comb begin
        accept     = (state == IDLE) && found && rst;
        busy       = (state != IDLE);
        resp_valid = (state == RESP);
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = accept && (i == int'(win));
        end
    end

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            start_r <= 1'b0;
            op_r    <= '0;
            a_r     <= '0;
            b_r     <= '0;
            id_r    <= '0;
            res_r   <= '0;
            dz_r    <= 1'b0;
        end else begin
            start_r <= accept;
            if (accept) begin
                op_r <= req_op[int'(win)*2 +: 2];
                a_r  <= req_a[int'(win)*3 +: 3];
                b_r  <= req_b[int'(win)*3 +: 3];
                id_r <= win;
            end
            if (state == EXEC && core_done) begin
                res_r <= core_result;
                dz_r  <= core_dz;
            end
        end
    end

    assign resp_id     = id_r;
    assign resp_result = res_r;
    assign resp_dz     = dz_r;

    alu_seq_core u_core (
        .clk    (CLK),
        .rst    (rst),
        .start  (start_r),
        .op     (op_r),
        .a      (a_r),
        .b      (b_r),
        .done   (core_done),
        .result (core_result),
        .dz     (core_dz)
    );

endmodule

// File: tb/tb_alu_req_scheduler.sv
// tb/tb_alu_req_scheduler.sv - self-checking bench for alu_req_scheduler (table vectors, corner sequences, random vs model)
module tb_alu_req_scheduler;

    localparam int N = 4;

    logic           CLK = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [2*N-1:0] req_op;
    logic [3*N-1:0] req_a;
    logic [3*N-1:0] req_b;
    logic           resp_valid;
    logic           resp_ready;
    logic [1:0]     resp_id;
    logic [5:0]     resp_result;
    logic           resp_dz;
    logic           busy;

    int checks = 0;
    int errors = 0;
    int model_ptr = 0;

    typedef struct {
        int         req;
        logic [1:0] op;
        logic [2:0] a;
        logic [2:0] b;
        int         res;
        int         dz;
        int         lat;
    } vec_t;

    vec_t vecs[5];

    alu_req_scheduler #(.NUM_REQ(N), .ID_W(2)) dut (
        .CLK         (CLK),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_result (resp_result),
        .resp_dz     (resp_dz),
        .busy        (busy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [1:0] op, input logic [2:0] a, input logic [2:0] b);
        req_op[2*i +: 2] = op;
        req_a[3*i +: 3]  = a;
        req_b[3*i +: 3]  = b;
    endtask

    function automatic int pick(input logic [N-1:0] m, input int p);
        for (int k = 0; k < N; k++) begin
            if (m[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic void ref_alu(input logic [1:0] op, input int a, input int b,
                                    output int r, output int dz, output int lat);
        dz  = 0;
        lat = (op < 2) ? 2 : 4;
        case (op)
            2'd0: r = a + b;
            2'd1: r = (a - b + 64) % 64;
            2'd2: r = a * b;
            default: begin
                if (b == 0) begin r = 63; dz = 1; end
                else r = a / b;
            end
        endcase
    endfunction

    task automatic advance(input int w);
`ifdef ALU_FIXED_PRIO_EN
        model_ptr = 0;
`else
        model_ptr = (w + 1) % N;
`endif
    endtask

    // Drives one transaction from the current negedge through the response handshake.
    task automatic run_txn(input int stall, output int w, output int waitc, output int lat,
                           output int id, output int res, output int dz,
                           output int quiet, output int stable);
        w = -1; waitc = 0; lat = 0; id = 0; res = 0; dz = 0; quiet = 0; stable = 0;
        #1;
        while (req_ready == '0 && waitc < 20) begin
            @(negedge CLK);
            waitc++;
        end
        for (int i = 0; i < N; i++) if (req_ready == N'(1 << i)) w = i;
        if (w < 0) return;
        if (stall > 0) resp_ready = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        lat = 1;
        quiet = 1;
        while (!resp_valid && lat < 10) begin
            if (req_ready != '0 || !busy) quiet = 0;
            @(negedge CLK);
            lat++;
        end
        if (req_ready != '0 || !busy) quiet = 0;
        id = resp_id; res = resp_result; dz = resp_dz;
        stable = 1;
        for (int s = 0; s < stall; s++) begin
            @(negedge CLK);
            if (!resp_valid || resp_id != id[1:0] || resp_result != res[5:0] ||
                resp_dz != dz[0] || req_ready != '0) stable = 0;
        end
        resp_ready = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        int w, waitc, lat, id, res, dz, quiet, stable, ew, er, edz, elat, seen;

        vecs[0] = '{1, 2'd2, 3'd7, 3'd7, 49, 0, 4};
        vecs[1] = '{0, 2'd1, 3'd2, 3'd5, 61, 0, 2};
        vecs[2] = '{0, 2'd0, 3'd7, 3'd7, 14, 0, 2};
        vecs[3] = '{2, 2'd3, 3'd5, 3'd0, 63, 1, 4};
        vecs[4] = '{2, 2'd3, 3'd7, 3'd2, 3,  0, 4};

        rst = 1'b0; req_valid = '1; req_op = '0; req_a = '0; req_b = '0; resp_ready = 1'b1;
        @(negedge CLK); @(negedge CLK);
        chk("reset_req_ready", int'(req_ready), 0);
        chk("reset_resp_valid", int'(resp_valid), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_resp_id", int'(resp_id), 0);
        chk("reset_resp_result", int'(resp_result), 0);
        chk("reset_resp_dz", int'(resp_dz), 0);
        req_valid = '0;
        rst = 1'b1;
        @(negedge CLK);

        foreach (vecs[v]) begin
            req_valid = N'(1 << vecs[v].req);
            set_req(vecs[v].req, vecs[v].op, vecs[v].a, vecs[v].b);
            run_txn(0, w, waitc, lat, id, res, dz, quiet, stable);
            chk("vec_grant", w, vecs[v].req);
            chk("vec_latency", lat, vecs[v].lat);
            chk("vec_id", id, vecs[v].req);
            chk("vec_result", res, vecs[v].res);
            chk("vec_dz", dz, vecs[v].dz);
            chk("vec_quiet", quiet, 1);
            advance(w);
        end
        req_valid = '0;

        rst = 1'b0; #1; rst = 1'b1; model_ptr = 0;
        @(negedge CLK);
        req_valid = '1;
        for (int i = 0; i < N; i++) set_req(i, 2'd0, 3'(i), 3'(i + 1));
        for (int n = 0; n < 5; n++) begin
            ew = pick(req_valid, model_ptr);
            run_txn(0, w, waitc, lat, id, res, dz, quiet, stable);
            chk("rr_grant", w, ew);
            chk("rr_id", id, ew);
            chk("rr_result", res, 2 * ew + 1);
            if (n > 0) chk("rr_back_to_back", waitc, 0);
            advance(w);
        end

        for (int i = 0; i < N; i++) set_req(i, 2'd2, 3'(i + 2), 3'(3));
        ew = pick(req_valid, model_ptr);
        run_txn(5, w, waitc, lat, id, res, dz, quiet, stable);
        chk("bp_grant", w, ew);
        chk("bp_result", res, (ew + 2) * 3);
        chk("bp_stable", stable, 1);
        chk("bp_quiet", quiet, 1);
        advance(w);
        ew = pick(req_valid, model_ptr);
        run_txn(0, w, waitc, lat, id, res, dz, quiet, stable);
        chk("bp_next_grant", w, ew);
        chk("bp_next_wait", waitc, 0);
        advance(w);

        req_valid = 4'b0010;
        set_req(1, 2'd2, 3'd7, 3'd7);
        #1;
        chk("rst_mid_grant", int'(req_ready), 2);
        @(posedge CLK);
        @(negedge CLK);
        @(negedge CLK);
        rst = 1'b0;
        req_valid = '0;
        #1;
        chk("rst_mid_outputs", int'({req_ready, resp_valid, busy, resp_id, resp_result, resp_dz}), 0);
        @(negedge CLK);
        rst = 1'b1;
        model_ptr = 0;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge CLK);
            if (resp_valid || busy) seen++;
        end
        chk("rst_mid_no_resp", seen, 0);
        req_valid = '1;
        for (int i = 0; i < N; i++) set_req(i, 2'd0, 3'd1, 3'd1);
        run_txn(0, w, waitc, lat, id, res, dz, quiet, stable);
        chk("rst_mid_next_grant", w, 0);
        advance(w);

        for (int t = 0; t < 40; t++) begin
            req_valid = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++)
                set_req(i, 2'($urandom), 3'($urandom), 3'($urandom));
            ew = pick(req_valid, model_ptr);
            ref_alu(req_op[2*ew +: 2], int'(req_a[3*ew +: 3]), int'(req_b[3*ew +: 3]), er, edz, elat);
            run_txn(int'($urandom_range(0, 2)), w, waitc, lat, id, res, dz, quiet, stable);
            chk("rnd_grant", w, ew);
            chk("rnd_id", id, ew);
            chk("rnd_result", res, er);
            chk("rnd_dz", dz, edz);
            chk("rnd_latency", lat, elat);
            chk("rnd_hold", quiet & stable, 1);
            advance(w);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
